// File: rtl/clint_lite_pkg.sv
// Shared constants and helpers for the core-local interruptor.
// Register offsets are byte addresses on the request/response port.
package clint_lite_pkg;

  localparam logic [31:0] MSIP_BASE     = 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_BASE = 32'h0000_4000;
  localparam logic [31:0] MTIME_OFFSET  = 32'h0000_BFF8;
  localparam logic [63:0] MTIME_RESET   = 64'h0;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_MSIP,
    REG_MTIMECMP,
    REG_MTIME
  } reg_sel_e;

  function automatic logic [63:0] apply_be(input logic [63:0] old,
                                           input logic [63:0] wdata,
                                           input logic [7:0]  be);
    logic [63:0] res;
    res = old;
    for (int i = 0; i < 8; i++)
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/sync_wedge.sv
// Two-flop synchroniser with rising-edge detect against a third flop.
// An input rise before edge N yields a one-cycle pulse between edges N+1 and N+2.
module sync_wedge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic serial_i,
  output logic r_edge_o
);

  logic [2:0] q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q <= '0;
    else         q <= {q[1:0], serial_i};
  end

  assign r_edge_o = q[1] & ~q[2];

endmodule

// File: rtl/clint_lite.sv
// Machine timer and software interrupt source for Ariane harts:
// mtime counter driven by the RTC, per-hart mtimecmp/msip, 1-cycle register port.
module clint_lite
  import clint_lite_pkg::*;
#(
  parameter int unsigned NrHarts   = 1,
  parameter int unsigned AddrWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rtc_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [63:0]          wdata_i,
  input  logic [7:0]           be_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [63:0]          rdata_o,
  output logic                 err_o,
  output logic [NrHarts-1:0]   timer_irq_o,
  output logic [NrHarts-1:0]   ipi_o
);

  logic                      tick;
  logic [63:0]               mtime;
  logic [31:0]               addr, msip_off, cmp_off;
  logic [3:0]                hart;
  reg_sel_e                  sel;
  logic                      wr;
  logic [63:0]               rd;
  logic [NrHarts-1:0][63:0]  mtimecmp;
  logic [NrHarts-1:0]        msip;

  sync_wedge i_sync_rtc (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .serial_i (rtc_i),
    .r_edge_o (tick)
  );

  assign gnt_o    = req_i;
  assign wr       = req_i & we_i;
  assign addr     = 32'(addr_i);
  // Offsets wrap below their base, so a single unsigned compare bounds each window.
  assign msip_off = addr - MSIP_BASE;
  assign cmp_off  = addr - MTIMECMP_BASE;

  always_comb begin
    sel  = REG_NONE;
    hart = '0;
    if (addr[31:3] == MTIME_OFFSET[31:3]) begin
      sel = REG_MTIME;
    end else if (msip_off < 32'(8 * NrHarts)) begin
      sel  = REG_MSIP;
      hart = 4'(msip_off >> 3);
    end else if (cmp_off < 32'(8 * NrHarts)) begin
      sel  = REG_MTIMECMP;
      hart = 4'(cmp_off >> 3);
    end
  end

  always_comb begin
    rd = '0;
    case (sel)
      REG_MTIME: rd = mtime;
      REG_MSIP: begin
        for (int h = 0; h < NrHarts; h++)
          if (hart == 4'(h)) rd = {63'b0, msip[h]};
      end
      REG_MTIMECMP: begin
        for (int h = 0; h < NrHarts; h++)
          if (hart == 4'(h)) rd = mtimecmp[h];
      end
      default: rd = '0;
    endcase
  end

  // A software write to mtime takes priority over a same-cycle tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     mtime <= MTIME_RESET;
    else if (wr && sel == REG_MTIME) mtime <= apply_be(mtime, wdata_i, be_i);
    else if (tick)                   mtime <= mtime + 64'd1;
  end

  for (genvar h = 0; h < NrHarts; h++) begin : g_hart
    logic        hit;
    logic [63:0] cmp_q;
    logic        msip_q, irq_q;

    assign hit = wr && (hart == 4'(h));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cmp_q  <= '1;
        msip_q <= 1'b0;
        irq_q  <= 1'b0;
      end else begin
        if (hit && sel == REG_MTIMECMP)        cmp_q  <= apply_be(cmp_q, wdata_i, be_i);
        if (hit && sel == REG_MSIP && be_i[0]) msip_q <= wdata_i[0];
        irq_q <= (mtime >= cmp_q);
      end
    end

    assign mtimecmp[h]    = cmp_q;
    assign msip[h]        = msip_q;
    assign timer_irq_o[h] = irq_q;
    assign ipi_o[h]       = msip_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= req_i;
      err_o    <= req_i && (sel == REG_NONE);
      rdata_o  <= (req_i && !we_i) ? rd : '0;
    end
  end

endmodule

// File: tb/tb_clint_lite.sv
// Bench for clint_lite: table of register accesses plus hand sequences for
// RTC timing, wrap, write/tick collision and mid-access reset.
module tb_clint_lite;

  logic        clk = 1'b0, rst_n = 1'b0, rtc = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [15:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [7:0]  be = '0;
  logic        gnt, rvalid, err;
  logic [63:0] rdata;
  logic [0:0]  timer_irq, ipi;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t sb[$];
  rsp_t exp_rsp;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] exp_rd;
    logic        exp_err;
    logic        exp_ipi;
    logic        exp_irq;
  } vec_t;
  vec_t tbl[16];

  clint_lite #(.NrHarts(1), .AddrWidth(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rtc_i       (rtc),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .be_i        (be),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .err_o       (err),
    .timer_irq_o (timer_irq),
    .ipi_o       (ipi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the request was accepted.
  task automatic access(input logic w, input logic [15:0] a, input logic [63:0] d,
                        input logic [7:0] b, input logic [63:0] exp_rd, input logic exp_e);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    chk("gnt", {63'b0, gnt}, 64'd1);
    sb.push_back('{rdata: exp_rd, err: exp_e});
    cyc(1);
    req = 1'b0; we = 1'b0;
    chk("rvalid", {63'b0, rvalid}, 64'd1);
  endtask

  task automatic rtc_pulse();
    rtc = 1'b1; cyc(4);
    rtc = 1'b0; cyc(4);
  endtask

  always @(negedge clk) begin
    if (rst_n && rvalid) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_rvalid: got rvalid=1 expected no response");
      end else begin
        exp_rsp = sb.pop_front();
        chk("rsp_rdata", rdata, exp_rsp.rdata);
        chk("rsp_err", {63'b0, err}, {63'b0, exp_rsp.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    //          we    addr      wdata                  be     exp_rd                 err   ipi   irq
    tbl[0]  = '{1'b0, 16'hBFF8, 64'h0,                 8'h00, 64'h0,                 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 16'h0000, 64'h0,                 8'h00, 64'h0,                 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 16'h4000, 64'h0,                 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 16'h0000, 64'h1,                 8'hFF, 64'h0,                 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 16'h0000, 64'h0,                 8'h00, 64'h1,                 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 16'h0000, 64'h0,                 8'hFF, 64'h0,                 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 64'h0,               1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 64'h0,                 8'h00, 64'h0,                 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 16'h0000, 64'h1,                 8'hFE, 64'h0,                 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 16'h8000, 64'h0,                 8'h00, 64'h0,                 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 16'h4008, 64'h0,                 8'hFF, 64'h0,                 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 16'h4000, 64'h0,                 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 16'h4008, 64'h0,                 8'h00, 64'h0,                 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 16'h0008, 64'h1,                 8'hFF, 64'h0,                 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 16'h4000, 64'h0,                 8'h0F, 64'h0,                 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 16'h4000, 64'h0,                 8'h00, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0, 1'b0};

    // Reset state
    cyc(3);
    chk("rst_rvalid", {63'b0, rvalid}, 64'd0);
    chk("rst_err", {63'b0, err}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_irq", {63'b0, timer_irq}, 64'd0);
    chk("rst_ipi", {63'b0, ipi}, 64'd0);
    rst_n = 1'b1;
    cyc(2);

    // Back-to-back table accesses
    for (int i = 0; i < 16; i++) begin
      access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].exp_rd, tbl[i].exp_err);
      chk($sformatf("vec%0d_ipi", i), {63'b0, ipi}, {63'b0, tbl[i].exp_ipi});
      chk($sformatf("vec%0d_irq", i), {63'b0, timer_irq}, {63'b0, tbl[i].exp_irq});
    end

    // Timer compare: irq one cycle after the fifth increment
    access(1'b1, 16'h4000, 64'd5, 8'hFF, 64'h0, 1'b0);
    repeat (4) rtc_pulse();
    chk("irq_at_4", {63'b0, timer_irq}, 64'd0);
    rtc = 1'b1;
    cyc(3);
    chk("irq_at_incr5", {63'b0, timer_irq}, 64'd0);
    cyc(1);
    chk("irq_after_incr5", {63'b0, timer_irq}, 64'd1);
    rtc = 1'b0;
    cyc(4);
    access(1'b0, 16'hBFF8, 64'h0, 8'h00, 64'd5, 1'b0);

    // Wrap of mtime with mtimecmp all ones
    access(1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1'b0);
    access(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1'b0);
    cyc(2);
    chk("irq_before_wrap", {63'b0, timer_irq}, 64'd1);
    access(1'b0, 16'hBFF8, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    rtc_pulse();
    chk("irq_after_wrap", {63'b0, timer_irq}, 64'd0);
    access(1'b0, 16'hBFF8, 64'h0, 8'h00, 64'h0, 1'b0);

    // Partial mtime write colliding with a tick: write wins
    access(1'b1, 16'hBFF8, 64'h1_0000_0000, 8'hFF, 64'h0, 1'b0);
    cyc(4);
    rtc = 1'b1;
    cyc(2);
    access(1'b1, 16'hBFF8, 64'h1234_5678, 8'h0F, 64'h0, 1'b0);
    rtc = 1'b0;
    cyc(4);
    access(1'b0, 16'hBFF8, 64'h0, 8'h00, 64'h1_1234_5678, 1'b0);

    // Read in a tick cycle returns the pre-increment value
    cyc(2);
    rtc = 1'b1;
    cyc(2);
    access(1'b0, 16'hBFF8, 64'h0, 8'h00, 64'h1_1234_5678, 1'b0);
    access(1'b0, 16'hBFF8, 64'h0, 8'h00, 64'h1_1234_5679, 1'b0);
    rtc = 1'b0;
    cyc(4);

    // Reset mid-access drops rvalid and clears state
    access(1'b1, 16'h0000, 64'h1, 8'hFF, 64'h0, 1'b0);
    chk("ipi_before_rst", {63'b0, ipi}, 64'd1);
    req = 1'b1; we = 1'b0; addr = 16'hBFF8;
    cyc(1);
    req = 1'b0;
    chk("rvalid_pre_rst", {63'b0, rvalid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rvalid_async_drop", {63'b0, rvalid}, 64'd0);
    chk("ipi_async_clr", {63'b0, ipi}, 64'd0);
    req = 1'b1;
    cyc(1);
    req = 1'b0;
    chk("rvalid_in_rst", {63'b0, rvalid}, 64'd0);
    rst_n = 1'b1;
    cyc(1);
    chk("rvalid_after_rst", {63'b0, rvalid}, 64'd0);
    access(1'b0, 16'hBFF8, 64'h0, 8'h00, 64'h0, 1'b0);
    access(1'b0, 16'h4000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    access(1'b0, 16'h0000, 64'h0, 8'h00, 64'h0, 1'b0);
    cyc(2);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
